// File: rtl/l2_mem_bridge_pkg.sv
// Shared constants and FSM encoding for the L2-to-system-memory bridge.
package l2_mem_bridge_pkg;
   localparam int DEF_PADDR_WIDTH    = 56;
   localparam int DEF_LINE_SIZE      = 64;
   localparam int DEF_BUS_DATA_WIDTH = 64;
   localparam int BUS_LEN_WIDTH      = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_WRESP,
      ST_RDATA,
      ST_ACK
   } bridge_state_t;

   function automatic int beats_per_line(input int line_size, input int bus_w);
      return (line_size * 8) / bus_w;
   endfunction
endpackage

// File: rtl/l2_mem_bridge_if.sv
// L2 memory-port interface and narrow system-bus interface used by the bridge.
interface l2_mem_if import l2_mem_bridge_pkg::*; #(
   parameter int PADDR_WIDTH = DEF_PADDR_WIDTH,
   parameter int LINE_SIZE   = DEF_LINE_SIZE
) ();
   logic                     mem_req;
   logic                     mem_we;
   logic [PADDR_WIDTH-1:0]   mem_addr;
   logic [LINE_SIZE*8-1:0]   mem_wdata;
   logic                     mem_ack;
   logic [LINE_SIZE*8-1:0]   mem_rdata;
   logic                     mem_error;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata, mem_error
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata, mem_error
   );
endinterface

interface sys_bus_if import l2_mem_bridge_pkg::*; #(
   parameter int PADDR_WIDTH    = DEF_PADDR_WIDTH,
   parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH
) ();
   logic                        bus_cmd_valid;
   logic                        bus_cmd_ready;
   logic                        bus_cmd_we;
   logic [PADDR_WIDTH-1:0]      bus_cmd_addr;
   logic [BUS_LEN_WIDTH-1:0]    bus_cmd_len;
   logic                        bus_wvalid;
   logic                        bus_wready;
   logic [BUS_DATA_WIDTH-1:0]   bus_wdata;
   logic                        bus_wlast;
   logic                        bus_bvalid;
   logic                        bus_berr;
   logic                        bus_rvalid;
   logic                        bus_rready;
   logic [BUS_DATA_WIDTH-1:0]   bus_rdata;
   logic                        bus_rlast;
   logic                        bus_rerr;

   modport master (
      output bus_cmd_valid, bus_cmd_we, bus_cmd_addr, bus_cmd_len,
             bus_wvalid, bus_wdata, bus_wlast, bus_rready,
      input  bus_cmd_ready, bus_wready, bus_bvalid, bus_berr,
             bus_rvalid, bus_rdata, bus_rlast, bus_rerr
   );
   modport slave (
      input  bus_cmd_valid, bus_cmd_we, bus_cmd_addr, bus_cmd_len,
             bus_wvalid, bus_wdata, bus_wlast, bus_rready,
      output bus_cmd_ready, bus_wready, bus_bvalid, bus_berr,
             bus_rvalid, bus_rdata, bus_rlast, bus_rerr
   );
endinterface

// File: rtl/l2_mem_bridge_line_beat_buffer.sv
// Read-line assembly register: one beat-wide slot written per accepted read beat.
module l2_mem_bridge_line_beat_buffer import l2_mem_bridge_pkg::*; #(
   parameter int BEATS          = 8,
   parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
   parameter int CNT_W          = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   beat_we,
   input  logic [CNT_W-1:0]                       beat_idx,
   input  logic [BUS_DATA_WIDTH-1:0]              beat_wdata,
   output logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   line
);
   logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] line_q, line_d;

   always_comb begin
      line_d = line_q;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_we && (beat_idx == CNT_W'(b))) line_d[b] = beat_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) line_q <= '0;
      else     line_q <= line_d;
   end

   assign line = line_q;
endmodule

// File: rtl/l2_mem_bridge.sv
// Converts one L2 line read/write into a fixed-length burst on the narrow memory bus.
module l2_mem_bridge import l2_mem_bridge_pkg::*; #(
   parameter int PADDR_WIDTH    = DEF_PADDR_WIDTH,
   parameter int LINE_SIZE      = DEF_LINE_SIZE,
   parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH
) (
   input  logic      clk,
   input  logic      rst,
   l2_mem_if.slave   l2,
   sys_bus_if.master bus
);
   localparam int BEATS = beats_per_line(LINE_SIZE, BUS_DATA_WIDTH);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]         LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [PADDR_WIDTH-1:0]   ALIGN_MASK = ~PADDR_WIDTH'(LINE_SIZE - 1);

   bridge_state_t                          state_q, state_d;
   logic [CNT_W-1:0]                       cnt_q, cnt_d;
   logic                                   err_q, err_d;
   logic                                   drop_q, drop_d;
   logic                                   we_q, we_d;
   logic [PADDR_WIDTH-1:0]                 addr_q, addr_d;
   logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   wline_q, wline_d;
   logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   rline;
   logic                                   rbeat_we;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      drop_d   = drop_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wline_d  = wline_q;
      rbeat_we = 1'b0;
      case (state_q)
         ST_IDLE: if (l2.mem_req) begin
            we_d   = l2.mem_we;
            addr_d = l2.mem_addr & ALIGN_MASK;
            if (l2.mem_we) wline_d = l2.mem_wdata;
            cnt_d   = '0;
            err_d   = 1'b0;
            drop_d  = 1'b0;
            state_d = ST_CMD;
         end
         ST_CMD: if (bus.bus_cmd_ready) state_d = we_q ? ST_WDATA : ST_RDATA;
         ST_WDATA: if (bus.bus_wready) begin
            if (cnt_q == LAST_BEAT) state_d = ST_WRESP;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         ST_WRESP: if (bus.bus_bvalid) begin
            err_d   = bus.bus_berr;
            state_d = ST_ACK;
         end
         ST_RDATA: if (bus.bus_rvalid) begin
            if (bus.bus_rerr) err_d = 1'b1;
            // After an over-long burst the line is complete; drain until rlast.
            if (drop_q) begin
               if (bus.bus_rlast) state_d = ST_ACK;
            end else begin
               rbeat_we = 1'b1;
               if (bus.bus_rlast) begin
                  if (cnt_q != LAST_BEAT) err_d = 1'b1;
                  state_d = ST_ACK;
               end else if (cnt_q == LAST_BEAT) begin
                  err_d  = 1'b1;
                  drop_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wline_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
      end
   end

   l2_mem_bridge_line_beat_buffer #(
      .BEATS(BEATS), .BUS_DATA_WIDTH(BUS_DATA_WIDTH), .CNT_W(CNT_W)
   ) u_rbuf (
      .clk        (clk),
      .rst        (rst),
      .beat_we    (rbeat_we),
      .beat_idx   (cnt_q),
      .beat_wdata (bus.bus_rdata),
      .line       (rline)
   );

   // Command and write-beat fields are gated by state so every output idles at 0.
   assign bus.bus_cmd_valid = (state_q == ST_CMD);
   assign bus.bus_cmd_we    = bus.bus_cmd_valid & we_q;
   assign bus.bus_cmd_addr  = bus.bus_cmd_valid ? addr_q : '0;
   assign bus.bus_cmd_len   = bus.bus_cmd_valid ? BUS_LEN_WIDTH'(BEATS - 1) : '0;
   assign bus.bus_wvalid    = (state_q == ST_WDATA);
   assign bus.bus_wdata     = bus.bus_wvalid ? wline_q[cnt_q] : '0;
   assign bus.bus_wlast     = bus.bus_wvalid && (cnt_q == LAST_BEAT);
   assign bus.bus_rready    = (state_q == ST_RDATA);
   assign l2.mem_ack        = (state_q == ST_ACK);
   assign l2.mem_error      = l2.mem_ack & err_q;
   assign l2.mem_rdata      = rline;
endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed, table-driven bench for l2_mem_bridge with a cycle-level bus responder.
module tb_l2_mem_bridge;
   localparam int AW = 56;
   localparam int LW = 512;
   localparam int DW = 64;
   localparam int NB = 8;

   typedef struct {
      bit          we;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      bit          wr_toggle;
      bit          berr;
      int          nbeats;
      int          rerr_beat;
      int          rlast_beat;
      bit          b2b;
      logic [DW-1:0] seed;
      logic [AW-1:0] exp_addr;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nerr = 0;
   logic [LW-1:0] last_rline = '0;
   logic [LW-1:0] ack_rdata;
   vec_t vecs[9];

   l2_mem_if  l2 ();
   sys_bus_if bus ();

   l2_mem_bridge dut (.clk(clk), .rst(rst), .l2(l2), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] mkline(input logic [DW-1:0] seed);
      logic [LW-1:0] r;
      for (int i = 0; i < NB; i++) r[i*DW +: DW] = seed + DW'(i);
      return r;
   endfunction

   function automatic vec_t rd(input logic [AW-1:0] a, input logic [DW-1:0] seed, input int nb,
                               input int rerr_b, input int rlast_b, input bit b2b,
                               input logic [AW-1:0] ea, input bit ee, input int lat);
      vec_t v;
      v = '{we: 0, addr: a, wdata: '0, wr_toggle: 0, berr: 0, nbeats: nb, rerr_beat: rerr_b,
            rlast_beat: rlast_b, b2b: b2b, seed: seed, exp_addr: ea, exp_err: ee, exp_lat: lat};
      return v;
   endfunction

   function automatic vec_t wr(input logic [AW-1:0] a, input logic [LW-1:0] d, input bit tog,
                               input bit be, input bit b2b, input logic [AW-1:0] ea,
                               input bit ee, input int lat);
      vec_t v;
      v = '{we: 1, addr: a, wdata: d, wr_toggle: tog, berr: be, nbeats: 0, rerr_beat: -1,
            rlast_beat: -1, b2b: b2b, seed: '0, exp_addr: ea, exp_err: ee, exp_lat: lat};
      return v;
   endfunction

   task automatic bus_idle();
      bus.bus_cmd_ready = 1'b0; bus.bus_wready = 1'b0;
      bus.bus_bvalid = 1'b0; bus.bus_berr = 1'b0;
      bus.bus_rvalid = 1'b0; bus.bus_rdata = '0; bus.bus_rlast = 1'b0; bus.bus_rerr = 1'b0;
   endtask

   // Called at a negedge; cycle 1 is the IDLE cycle in which the request is first visible.
   task automatic run_txn(input vec_t v);
      int cyc, ncmd, wb, rb;
      bit bsent, done;
      logic [LW-1:0] exp_line;
      cyc = 1; ncmd = 0; wb = 0; rb = 0; bsent = 0; done = 0;
      l2.mem_req = 1'b1; l2.mem_we = v.we; l2.mem_addr = v.addr; l2.mem_wdata = v.wdata;
      while (!done && cyc < 60) begin
         @(posedge clk); @(negedge clk); cyc++;
         if (l2.mem_ack) begin
            done = 1;
            l2.mem_req = 1'b0;
            bus_idle();
            ack_rdata = l2.mem_rdata;
            exp_line = last_rline;
            if (!v.we)
               for (int i = 0; i < v.nbeats && i < NB; i++) exp_line[i*DW +: DW] = v.seed + DW'(i);
            last_rline = exp_line;
            chk("ack_latency", LW'(cyc), LW'(v.exp_lat));
            chk("mem_error", LW'(l2.mem_error), LW'(v.exp_err));
            chk("mem_rdata", l2.mem_rdata, exp_line);
            chk("cmd_count", LW'(ncmd), LW'(1));
            chk("wbeats", LW'(wb), LW'(v.we ? NB : 0));
         end else begin
            bus.bus_bvalid = 1'b0; bus.bus_berr = 1'b0;
            if (wb == NB && !bsent) begin
               bus.bus_bvalid = 1'b1; bus.bus_berr = v.berr; bsent = 1;
            end
            bus.bus_cmd_ready = 1'b1;
            if (bus.bus_cmd_valid) begin
               ncmd++;
               if (ncmd == 1) begin
                  chk("cmd_addr", LW'(bus.bus_cmd_addr), LW'(v.exp_addr));
                  chk("cmd_len", LW'(bus.bus_cmd_len), LW'(NB - 1));
                  chk("cmd_we", LW'(bus.bus_cmd_we), LW'(v.we));
               end
            end
            bus.bus_wready = v.wr_toggle ? ((cyc % 2) == 1) : 1'b1;
            if (bus.bus_wvalid && bus.bus_wready) begin
               chk("wdata_beat", LW'(bus.bus_wdata), LW'(v.wdata[wb*DW +: DW]));
               chk("wlast", LW'(bus.bus_wlast), LW'(wb == NB - 1));
               wb++;
            end
            bus.bus_rvalid = 1'b0; bus.bus_rlast = 1'b0; bus.bus_rerr = 1'b0;
            if (bus.bus_rready && rb < v.nbeats) begin
               bus.bus_rvalid = 1'b1;
               bus.bus_rdata  = v.seed + DW'(rb);
               bus.bus_rlast  = (rb == v.rlast_beat);
               bus.bus_rerr   = (rb == v.rerr_beat);
               rb++;
            end
         end
      end
      if (!done) begin
         ncmp++; nerr++;
         $display("FAIL txn_timeout: no mem_ack after %0d cycles (addr %0h)", cyc, v.addr);
         l2.mem_req = 1'b0;
         bus_idle();
      end
   endtask

   initial begin
      logic any_out;
      int k, wb;
      l2.mem_req = 1'b0; l2.mem_we = 1'b0; l2.mem_addr = '0; l2.mem_wdata = '0;
      bus_idle();

      vecs[0] = rd(56'h1000, 64'h0, 8, -1, 7, 0, 56'h1000, 0, 11);
      vecs[1] = wr(56'h2040, {8{64'hA5A5_A5A5_A5A5_A5A5}}, 1, 0, 0, 56'h2040, 0, 19);
      vecs[2] = wr(56'h30ff7, mkline(64'hDEAD_0000_0000_0000), 0, 1, 0, 56'h30fc0, 1, 12);
      vecs[3] = rd(56'h1234, 64'h500, 8, 3, 7, 0, 56'h1200, 1, 11);
      vecs[4] = rd(56'h5000, 64'h600, 6, -1, 5, 0, 56'h5000, 1, 9);
      vecs[5] = rd(56'h4000, 64'h700, 8, -1, 7, 1, 56'h4000, 0, 12);
      vecs[6] = rd(56'h6000, 64'h800, 10, -1, 9, 0, 56'h6000, 1, 13);
      vecs[7] = wr(56'h7000, mkline(64'hBEEF_0000_0000_0000), 0, 0, 0, 56'h7000, 0, 12);
      vecs[8] = rd(56'h8040, 64'h900, 8, -1, 7, 1, 56'h8040, 0, 12);

      #12;
      any_out = l2.mem_ack | l2.mem_error | (|l2.mem_rdata) | bus.bus_cmd_valid | bus.bus_cmd_we |
                (|bus.bus_cmd_addr) | (|bus.bus_cmd_len) | bus.bus_wvalid | (|bus.bus_wdata) |
                bus.bus_wlast | bus.bus_rready;
      chk("reset_outputs", LW'(any_out), LW'(0));
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         if (!vecs[i].b2b)
            repeat (2) begin
               @(posedge clk); @(negedge clk);
               chk("idle_quiet", LW'({l2.mem_ack, bus.bus_cmd_valid}), LW'(0));
            end
         run_txn(vecs[i]);
         if (i == 0) begin
            chk("rd0_beat0", LW'(ack_rdata[63:0]), LW'(64'h0));
            chk("rd0_beat7", LW'(ack_rdata[511:448]), LW'(64'h7));
         end
      end

      // Reset while beat 4 of a write is on the bus.
      @(posedge clk); @(negedge clk);
      l2.mem_req = 1'b1; l2.mem_we = 1'b1; l2.mem_addr = 56'h9000;
      l2.mem_wdata = mkline(64'hCAFE_0000_0000_0000);
      wb = 0; k = 0;
      while (wb < 4 && k < 40) begin
         @(posedge clk); @(negedge clk); k++;
         bus.bus_cmd_ready = 1'b1; bus.bus_wready = 1'b1;
         if (bus.bus_wvalid && bus.bus_wready) wb++;
      end
      if (wb < 4) begin
         ncmp++; nerr++;
         $display("FAIL rst_seq_timeout: only %0d write beats accepted", wb);
      end
      @(posedge clk); @(negedge clk);
      chk("beat4_wdata", LW'(bus.bus_wdata), LW'(64'hCAFE_0000_0000_0004));
      rst = 1'b1;
      l2.mem_req = 1'b0;
      bus_idle();
      #1;
      any_out = l2.mem_ack | l2.mem_error | (|l2.mem_rdata) | bus.bus_cmd_valid | bus.bus_cmd_we |
                (|bus.bus_cmd_addr) | (|bus.bus_cmd_len) | bus.bus_wvalid | (|bus.bus_wdata) |
                bus.bus_wlast | bus.bus_rready;
      chk("midburst_rst_outputs", LW'(any_out), LW'(0));
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      last_rline = '0;
      @(posedge clk); @(negedge clk);
      run_txn(rd(56'hA0C0, 64'hF00, 8, -1, 7, 0, 56'hA0C0, 0, 11));

      @(posedge clk); @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
